path_history_train_ctrl: RTL and testbench
==========================================

PATH_HISTORY_TRAIN_CTRL -- requirements
Module: path_history_train_ctrl

Interface
REQ-001 SHALL take parameter PATH_LEN, default 4: number of 32-bit branch PCs in a path history.
REQ-002 SHALL take parameter DEPTH, default 8 (power of two): number of in-flight branch checkpoints.
REQ-003 SHALL take parameter PTR_BITS, default 3 (log2 DEPTH): width of a checkpoint tag.
REQ-004 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port fetch_br_valid  in  1  a predicted branch is offered at fetch.
REQ-007 SHALL have port fetch_pc  in  32  PC of the offered branch.
REQ-008 SHALL have port fetch_pred_taken  in  1  direction predicted for the offered branch.
REQ-009 SHALL have port fetch_ready  out  1  the offered branch is accepted this cycle.
REQ-010 SHALL have port fetch_tag  out  PTR_BITS  checkpoint tag allocated to the accepted branch.
REQ-011 SHALL have port spec_path  out  [PATH_LEN-1:0][31:0]  speculative path history for the predictor.
REQ-012 SHALL have port resolve_valid  in  1  a branch resolved in execute.
REQ-013 SHALL have port resolve_tag  in  PTR_BITS  checkpoint tag of the resolved branch.
REQ-014 SHALL have port resolve_taken  in  1  actual direction of the resolved branch.
REQ-015 SHALL have port resolve_mispredict  in  1  actual direction differs from the prediction.
REQ-016 SHALL have port flush  in  1  full pipeline flush (exception or trap).
REQ-017 SHALL have port train_en  out  1  single-cycle training pulse for the predictor.
REQ-018 SHALL have port train_pc  out  32  PC of the branch being trained.
REQ-019 SHALL have port train_path  out  [PATH_LEN-1:0][31:0]  path history used for that branch's prediction.
REQ-020 SHALL have port actual_taken  out  1  resolved direction of the branch being trained.
REQ-021 SHALL have port count  out  PTR_BITS+1  number of occupied checkpoints.

Function
REQ-022 SHALL hold checkpoints in an in-order circular queue (head = oldest, tail = next free); each entry holds pc, pred_taken, snapshot path, resolved, taken.
REQ-023 SHALL drive fetch_ready = !full && !flush && !(resolve_valid && resolve_mispredict), combinationally.
REQ-024 SHALL drive fetch_tag = tail, combinationally.
REQ-025 SHALL, on push (fetch_br_valid && fetch_ready), write the entry at tail with snapshot = current spec_path, resolved = 0, and increment tail modulo DEPTH.
REQ-026 SHALL, on push, update spec_path next cycle to shift in fetch_pc: new[0] = fetch_pc, new[i] = old[i-1].
REQ-027 SHALL, on resolve_valid for an occupied tag, set resolved = 1 and taken = resolve_taken for that entry.
REQ-028 SHALL ignore any resolve whose tag is not currently occupied.
REQ-029 SHALL, on resolve with mispredict, squash all entries younger than resolve_tag (tail = resolve_tag+1) and set spec_path to that entry's snapshot shifted with that entry's pc.
REQ-030 SHALL maintain an architectural path arch_path, shifting in an entry's pc when that entry commits.
REQ-031 SHALL commit the head when its registered resolved bit is 1 and flush is 0, at most one entry per cycle: pop the head, register train_en = 1, train_pc = pc, train_path = snapshot, actual_taken = taken.
REQ-032 SHALL deassert train_en in every cycle with no commit; train_pc, train_path and actual_taken SHALL hold their last values.
REQ-033 SHALL make a resolve of the head visible to commit one cycle later, so train_en rises at the earliest on the second edge after the resolve.
REQ-034 SHALL give flush priority over every other event: empty the queue, set spec_path = registered arch_path, suppress that cycle's commit and train_en, and drop any push or resolve in the same cycle.
REQ-035 SHALL let a push and a commit in the same cycle both take effect (count unchanged).
REQ-036 SHALL accept no push while full, even when a commit occurs in the same cycle.
REQ-037 SHALL keep the head entry intact when a mispredict hits the head's tag; only younger entries are squashed.

Reset
REQ-038 SHALL, while rst is high, asynchronously clear head, tail, count, all resolved bits, spec_path, arch_path, train_en, train_pc, train_path and actual_taken to zero.
REQ-039 SHALL, on rst during activity, discard all in-flight checkpoints and assert no train_en until new branches are pushed and resolved.

Structure
REQ-040 SHALL place PATH_LEN, DEPTH, PTR_BITS, the path type and the checkpoint entry struct in the shared CPU package, which the predictor also uses.
REQ-041 SHALL implement the circular checkpoint store as one sub-module, path_ckpt_queue; the path registers and commit logic SHALL stay in the top module.

Verification
REQ-042 SHALL be verified with: push PCs 0x100, 0x104, 0x108 -> spec_path = {0,0x108? no} ordered as [0]=0x108, [1]=0x104, [2]=0x100, [3]=0; count = 3.
REQ-043 SHALL be verified with: push 0x100 (tag 0), then resolve tag 0 taken -> train_en pulses one cycle with train_pc = 0x100, train_path = all zero, actual_taken = 1; count = 0.
REQ-044 SHALL be verified with: push tags 0..3, then mispredict on tag 1 -> count = 2, fetch_tag = 2, spec_path[0] = PC of tag 1.
REQ-045 SHALL be verified with: push 8 entries -> fetch_ready = 0; a 9th offer is not accepted; resolve head -> next offer accepted after the commit.
REQ-046 SHALL be verified with: push 2, commit 1, then flush -> count = 0, spec_path = arch_path (spec_path[0] = committed PC), no train_en in the flush cycle.
REQ-047 SHALL be verified with: assert rst asynchronously mid-burst -> all outputs zero immediately, before the next clk edge.

Source files
------------

// File: rtl/path_history_train_ctrl_pkg.sv
// Shared CPU package: path-history geometry, path type and checkpoint entry format.
// The branch predictor imports the same definitions.
package path_history_train_ctrl_pkg;

    localparam int CPU_PATH_LEN = 4;
    localparam int CPU_DEPTH    = 8;
    localparam int CPU_PTR_BITS = 3;

    typedef logic [CPU_PATH_LEN-1:0][31:0] path_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        path_t       snapshot;
        logic        resolved;
        logic        taken;
    } ckpt_t;

    // Youngest PC enters at index 0; the oldest falls off the top.
    function automatic path_t shift_path(input path_t p, input logic [31:0] pc);
        return {p[CPU_PATH_LEN-2:0], pc};
    endfunction

endpackage

// File: rtl/path_ckpt_queue.sv
// In-order circular store of in-flight branch checkpoints (head = oldest, tail = next free).
// Handles push, out-of-order resolve, squash on mispredict, commit pop and flush.
module path_ckpt_queue
    import path_history_train_ctrl_pkg::*;
#(
    parameter int DEPTH    = CPU_DEPTH,
    parameter int PTR_BITS = CPU_PTR_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [31:0]         push_pc,
    input  logic                push_pred,
    input  path_t               push_snap,
    input  logic                pop,
    input  logic                flush,
    input  logic                resolve_valid,
    input  logic [PTR_BITS-1:0] resolve_tag,
    input  logic                resolve_taken,
    input  logic                resolve_mispredict,
    output logic                full,
    output logic [PTR_BITS-1:0] tail,
    output logic [PTR_BITS:0]   count,
    output logic                resolve_hit,
    output ckpt_t               head_entry,
    output logic [31:0]         res_pc,
    output path_t               res_snap
);

    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
    localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS+1)'(DEPTH);

    logic [PTR_BITS-1:0] head_q;
    logic [PTR_BITS-1:0] tail_q;
    logic [PTR_BITS:0]   count_q;
    logic [DEPTH-1:0]    resolved_q;
    logic [DEPTH-1:0]    taken_q;

    logic [31:0] pc_mem   [DEPTH];
    logic        pred_mem [DEPTH];
    path_t       snap_mem [DEPTH];

    logic [PTR_BITS-1:0] offset;
    logic [PTR_BITS:0]   pop_dec;
    logic                mispredict;

    // A tag is occupied when its distance from head is below the occupancy.
    assign offset      = resolve_tag - head_q;
    assign resolve_hit = resolve_valid && ({1'b0, offset} < count_q);
    assign mispredict  = resolve_hit && resolve_mispredict;
    assign pop_dec     = pop ? CNT_ONE : '0;

    assign full  = (count_q == CNT_FULL);
    assign tail  = tail_q;
    assign count = count_q;

    assign head_entry = '{pc:         pc_mem[head_q],
                          pred_taken: pred_mem[head_q],
                          snapshot:   snap_mem[head_q],
                          resolved:   resolved_q[head_q],
                          taken:      taken_q[head_q]};
    assign res_pc   = pc_mem[resolve_tag];
    assign res_snap = snap_mem[resolve_tag];

    // NOTE: only control state is reset; the payload array is always written
    // before it is read, so it needs no reset and stays a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= push_pc;
            pred_mem[tail_q] <= push_pred;
            snap_mem[tail_q] <= push_snap;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resolved_q <= '0;
            taken_q    <= '0;
        end else if (flush) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resolved_q <= '0;
        end else begin
            if (push)
                resolved_q[tail_q] <= 1'b0;
            if (resolve_hit) begin
                resolved_q[resolve_tag] <= 1'b1;
                taken_q[resolve_tag]    <= resolve_taken;
            end
            if (pop)
                head_q <= head_q + PTR_ONE;
            // Mispredict keeps the resolving entry and drops everything younger.
            if (mispredict) begin
                tail_q  <= resolve_tag + PTR_ONE;
                count_q <= {1'b0, offset} + CNT_ONE - pop_dec;
            end else begin
                if (push)
                    tail_q <= tail_q + PTR_ONE;
                count_q <= count_q + (push ? CNT_ONE : '0) - pop_dec;
            end
        end
    end

endmodule

// File: rtl/path_history_train_ctrl.sv
// Path-history checkpointing and predictor training control: speculative and
// architectural path registers, commit of resolved branches, flush recovery.
module path_history_train_ctrl
    import path_history_train_ctrl_pkg::*;
#(
    parameter int PATH_LEN = CPU_PATH_LEN,
    parameter int DEPTH    = CPU_DEPTH,
    parameter int PTR_BITS = CPU_PTR_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_br_valid,
    input  logic [31:0]              fetch_pc,
    input  logic                     fetch_pred_taken,
    output logic                     fetch_ready,
    output logic [PTR_BITS-1:0]      fetch_tag,
    output logic [PATH_LEN-1:0][31:0] spec_path,
    input  logic                     resolve_valid,
    input  logic [PTR_BITS-1:0]      resolve_tag,
    input  logic                     resolve_taken,
    input  logic                     resolve_mispredict,
    input  logic                     flush,
    output logic                     train_en,
    output logic [31:0]              train_pc,
    output logic [PATH_LEN-1:0][31:0] train_path,
    output logic                     actual_taken,
    output logic [PTR_BITS:0]        count
);

    logic        full;
    logic        push;
    logic        commit;
    logic        resolve_hit;
    logic        mispredict;
    ckpt_t       head_entry;
    logic [31:0] res_pc;
    path_t       res_snap;
    path_t       arch_path;
    logic        unused_pred;

    assign fetch_ready = !full && !flush && !(resolve_valid && resolve_mispredict);
    assign push        = fetch_br_valid && fetch_ready;
    assign commit      = head_entry.resolved && (count != '0) && !flush;
    assign mispredict  = resolve_hit && resolve_mispredict && !flush;

    // The predicted direction is kept for the predictor side; training uses the actual one.
    assign unused_pred = head_entry.pred_taken;

    path_ckpt_queue #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_queue (
        .clk                (clk),
        .rst                (rst),
        .push               (push),
        .push_pc            (fetch_pc),
        .push_pred          (fetch_pred_taken),
        .push_snap          (spec_path),
        .pop                (commit),
        .flush              (flush),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .full               (full),
        .tail               (fetch_tag),
        .count              (count),
        .resolve_hit        (resolve_hit),
        .head_entry         (head_entry),
        .res_pc             (res_pc),
        .res_snap           (res_snap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_path    <= '0;
            arch_path    <= '0;
            train_en     <= 1'b0;
            train_pc     <= '0;
            train_path   <= '0;
            actual_taken <= 1'b0;
        end else begin
            train_en <= commit;
            if (commit) begin
                train_pc     <= head_entry.pc;
                train_path   <= head_entry.snapshot;
                actual_taken <= head_entry.taken;
                arch_path    <= shift_path(arch_path, head_entry.pc);
            end
            // Flush restores the committed history, a mispredict rebuilds from the checkpoint.
            if (flush)
                spec_path <= arch_path;
            else if (mispredict)
                spec_path <= shift_path(res_snap, res_pc);
            else if (push)
                spec_path <= shift_path(spec_path, fetch_pc);
        end
    end

endmodule

// File: tb/tb_path_history_train_ctrl.sv
// Directed bench for path_history_train_ctrl: one task per scenario, hand-computed expectations.
module tb_path_history_train_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_br_valid;
    logic [31:0]       fetch_pc;
    logic              fetch_pred_taken;
    logic              fetch_ready;
    logic [2:0]        fetch_tag;
    logic [3:0][31:0]  spec_path;
    logic              resolve_valid;
    logic [2:0]        resolve_tag;
    logic              resolve_taken;
    logic              resolve_mispredict;
    logic              flush;
    logic              train_en;
    logic [31:0]       train_pc;
    logic [3:0][31:0]  train_path;
    logic              actual_taken;
    logic [3:0]        count;

    int passed = 0;
    int total  = 0;

    path_history_train_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_br_valid     (fetch_br_valid),
        .fetch_pc           (fetch_pc),
        .fetch_pred_taken   (fetch_pred_taken),
        .fetch_ready        (fetch_ready),
        .fetch_tag          (fetch_tag),
        .spec_path          (spec_path),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .flush              (flush),
        .train_en           (train_en),
        .train_pc           (train_pc),
        .train_path         (train_path),
        .actual_taken       (actual_taken),
        .count              (count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_br_valid     = 1'b0;
        fetch_pc           = '0;
        fetch_pred_taken   = 1'b0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_taken      = 1'b0;
        resolve_mispredict = 1'b0;
        flush              = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic push_br(input logic [31:0] pc);
        fetch_br_valid = 1'b1;
        fetch_pc       = pc;
        tick();
        fetch_br_valid = 1'b0;
    endtask

    task automatic resolve(input logic [2:0] tag, input logic taken, input logic mp);
        resolve_valid      = 1'b1;
        resolve_tag        = tag;
        resolve_taken      = taken;
        resolve_mispredict = mp;
        tick();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        total++; if (fetch_tag !== 3'd0) $display("FAIL reset_tag: got %0d want 0", fetch_tag); else passed++;
        total++; if (spec_path !== 128'd0) $display("FAIL reset_spec: got %h want 0", spec_path); else passed++;
        total++; if (train_en !== 1'b0) $display("FAIL reset_train_en: got %b want 0", train_en); else passed++;
        total++; if (fetch_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", fetch_ready); else passed++;
        #10;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_push();
        apply_reset();
        push_br(32'h100);
        push_br(32'h104);
        push_br(32'h108);
        total++; if (spec_path !== {32'h0, 32'h100, 32'h104, 32'h108})
            $display("FAIL push_spec: got %h want %h", spec_path, {32'h0, 32'h100, 32'h104, 32'h108}); else passed++;
        total++; if (count !== 4'd3) $display("FAIL push_count: got %0d want 3", count); else passed++;
        total++; if (fetch_tag !== 3'd3) $display("FAIL push_tag: got %0d want 3", fetch_tag); else passed++;
    endtask

    task automatic test_commit();
        apply_reset();
        push_br(32'h100);
        resolve(3'd0, 1'b1, 1'b0);
        total++; if (train_en !== 1'b0) $display("FAIL commit_early: got %b want 0", train_en); else passed++;
        tick();
        total++; if (train_en !== 1'b1) $display("FAIL commit_en: got %b want 1", train_en); else passed++;
        total++; if (train_pc !== 32'h100) $display("FAIL commit_pc: got %h want 100", train_pc); else passed++;
        total++; if (train_path !== 128'd0) $display("FAIL commit_path: got %h want 0", train_path); else passed++;
        total++; if (actual_taken !== 1'b1) $display("FAIL commit_taken: got %b want 1", actual_taken); else passed++;
        total++; if (count !== 4'd0) $display("FAIL commit_count: got %0d want 0", count); else passed++;
        tick();
        total++; if (train_en !== 1'b0) $display("FAIL commit_pulse: got %b want 0", train_en); else passed++;
        total++; if (train_pc !== 32'h100) $display("FAIL commit_hold: got %h want 100", train_pc); else passed++;
    endtask

    task automatic test_mispredict();
        apply_reset();
        push_br(32'h200);
        push_br(32'h204);
        push_br(32'h208);
        push_br(32'h20c);
        resolve_valid      = 1'b1;
        resolve_tag        = 3'd1;
        resolve_taken      = 1'b1;
        resolve_mispredict = 1'b1;
        fetch_br_valid     = 1'b1;
        fetch_pc           = 32'h900;
        #1;
        total++; if (fetch_ready !== 1'b0) $display("FAIL mp_ready: got %b want 0", fetch_ready); else passed++;
        tick();
        clear_inputs();
        total++; if (count !== 4'd2) $display("FAIL mp_count: got %0d want 2", count); else passed++;
        total++; if (fetch_tag !== 3'd2) $display("FAIL mp_tag: got %0d want 2", fetch_tag); else passed++;
        total++; if (spec_path !== {32'h0, 32'h0, 32'h200, 32'h204})
            $display("FAIL mp_spec: got %h want %h", spec_path, {32'h0, 32'h0, 32'h200, 32'h204}); else passed++;
        total++; if (train_en !== 1'b0) $display("FAIL mp_no_train: got %b want 0", train_en); else passed++;
        // Tag 3 was squashed; its resolve must be ignored.
        resolve(3'd3, 1'b1, 1'b1);
        total++; if (count !== 4'd2) $display("FAIL stale_count: got %0d want 2", count); else passed++;
        total++; if (spec_path !== {32'h0, 32'h0, 32'h200, 32'h204})
            $display("FAIL stale_spec: got %h want %h", spec_path, {32'h0, 32'h0, 32'h200, 32'h204}); else passed++;
        resolve(3'd0, 1'b0, 1'b1);
        total++; if (count !== 4'd1) $display("FAIL head_mp_count: got %0d want 1", count); else passed++;
        total++; if (fetch_tag !== 3'd1) $display("FAIL head_mp_tag: got %0d want 1", fetch_tag); else passed++;
        total++; if (spec_path !== {32'h0, 32'h0, 32'h0, 32'h200})
            $display("FAIL head_mp_spec: got %h want %h", spec_path, {32'h0, 32'h0, 32'h0, 32'h200}); else passed++;
        tick();
        total++; if (train_en !== 1'b1) $display("FAIL head_mp_train: got %b want 1", train_en); else passed++;
        total++; if (train_pc !== 32'h200) $display("FAIL head_mp_pc: got %h want 200", train_pc); else passed++;
        total++; if (actual_taken !== 1'b0) $display("FAIL head_mp_taken: got %b want 0", actual_taken); else passed++;
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 8; i++) push_br(32'h300 + 32'(4 * i));
        total++; if (count !== 4'd8) $display("FAIL full_count: got %0d want 8", count); else passed++;
        total++; if (fetch_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", fetch_ready); else passed++;
        fetch_br_valid = 1'b1;
        fetch_pc       = 32'h400;
        tick();
        total++; if (count !== 4'd8) $display("FAIL full_reject_count: got %0d want 8", count); else passed++;
        total++; if (spec_path[0] !== 32'h31c) $display("FAIL full_reject_spec: got %h want 31c", spec_path[0]); else passed++;
        resolve(3'd0, 1'b1, 1'b0);
        tick();
        total++; if (count !== 4'd7) $display("FAIL full_commit_count: got %0d want 7", count); else passed++;
        total++; if (train_en !== 1'b1) $display("FAIL full_commit_en: got %b want 1", train_en); else passed++;
        total++; if (train_pc !== 32'h300) $display("FAIL full_commit_pc: got %h want 300", train_pc); else passed++;
        total++; if (fetch_ready !== 1'b1) $display("FAIL full_ready_again: got %b want 1", fetch_ready); else passed++;
        tick();
        fetch_br_valid = 1'b0;
        total++; if (count !== 4'd8) $display("FAIL full_refill_count: got %0d want 8", count); else passed++;
        total++; if (spec_path[0] !== 32'h400) $display("FAIL full_refill_spec: got %h want 400", spec_path[0]); else passed++;
        total++; if (fetch_tag !== 3'd1) $display("FAIL full_refill_tag: got %0d want 1", fetch_tag); else passed++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        push_br(32'h700);
        resolve(3'd0, 1'b1, 1'b0);
        push_br(32'h704);
        total++; if (count !== 4'd1) $display("FAIL b2b_count: got %0d want 1", count); else passed++;
        total++; if (train_en !== 1'b1) $display("FAIL b2b_en: got %b want 1", train_en); else passed++;
        total++; if (train_pc !== 32'h700) $display("FAIL b2b_pc: got %h want 700", train_pc); else passed++;
        total++; if (fetch_tag !== 3'd2) $display("FAIL b2b_tag: got %0d want 2", fetch_tag); else passed++;
        total++; if (spec_path !== {32'h0, 32'h0, 32'h700, 32'h704})
            $display("FAIL b2b_spec: got %h want %h", spec_path, {32'h0, 32'h0, 32'h700, 32'h704}); else passed++;
        resolve(3'd1, 1'b0, 1'b0);
        total++; if (train_en !== 1'b0) $display("FAIL b2b_gap: got %b want 0", train_en); else passed++;
        tick();
        total++; if (train_en !== 1'b1) $display("FAIL b2b_second_en: got %b want 1", train_en); else passed++;
        total++; if (train_pc !== 32'h704) $display("FAIL b2b_second_pc: got %h want 704", train_pc); else passed++;
        total++; if (train_path !== {32'h0, 32'h0, 32'h0, 32'h700})
            $display("FAIL b2b_second_path: got %h want %h", train_path, {32'h0, 32'h0, 32'h0, 32'h700}); else passed++;
    endtask

    task automatic test_flush();
        apply_reset();
        push_br(32'h500);
        push_br(32'h504);
        resolve(3'd0, 1'b1, 1'b0);
        resolve(3'd1, 1'b0, 1'b0);
        total++; if (train_en !== 1'b1) $display("FAIL flush_pre_en: got %b want 1", train_en); else passed++;
        total++; if (count !== 4'd1) $display("FAIL flush_pre_count: got %0d want 1", count); else passed++;
        flush              = 1'b1;
        fetch_br_valid     = 1'b1;
        fetch_pc           = 32'h600;
        resolve_valid      = 1'b1;
        resolve_tag        = 3'd1;
        resolve_mispredict = 1'b1;
        #1;
        total++; if (fetch_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", fetch_ready); else passed++;
        tick();
        clear_inputs();
        total++; if (count !== 4'd0) $display("FAIL flush_count: got %0d want 0", count); else passed++;
        total++; if (train_en !== 1'b0) $display("FAIL flush_train_en: got %b want 0", train_en); else passed++;
        total++; if (train_pc !== 32'h500) $display("FAIL flush_train_hold: got %h want 500", train_pc); else passed++;
        total++; if (spec_path !== {32'h0, 32'h0, 32'h0, 32'h500})
            $display("FAIL flush_spec: got %h want %h", spec_path, {32'h0, 32'h0, 32'h0, 32'h500}); else passed++;
        total++; if (fetch_tag !== 3'd0) $display("FAIL flush_tag: got %0d want 0", fetch_tag); else passed++;
        tick();
        total++; if (train_en !== 1'b0) $display("FAIL flush_after_en: got %b want 0", train_en); else passed++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_br(32'h800);
        resolve(3'd0, 1'b1, 1'b0);
        push_br(32'h804);
        total++; if (train_en !== 1'b1) $display("FAIL arst_pre_en: got %b want 1", train_en); else passed++;
        total++; if (count !== 4'd1) $display("FAIL arst_pre_count: got %0d want 1", count); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (train_en !== 1'b0) $display("FAIL arst_en: got %b want 0", train_en); else passed++;
        total++; if (train_pc !== 32'h0) $display("FAIL arst_pc: got %h want 0", train_pc); else passed++;
        total++; if (train_path !== 128'd0) $display("FAIL arst_path: got %h want 0", train_path); else passed++;
        total++; if (actual_taken !== 1'b0) $display("FAIL arst_taken: got %b want 0", actual_taken); else passed++;
        total++; if (count !== 4'd0) $display("FAIL arst_count: got %0d want 0", count); else passed++;
        total++; if (spec_path !== 128'd0) $display("FAIL arst_spec: got %h want 0", spec_path); else passed++;
        total++; if (fetch_tag !== 3'd0) $display("FAIL arst_tag: got %0d want 0", fetch_tag); else passed++;
        #2;
        rst = 1'b0;
        tick();
        tick();
        tick();
        total++; if (train_en !== 1'b0) $display("FAIL arst_quiet_en: got %b want 0", train_en); else passed++;
        total++; if (count !== 4'd0) $display("FAIL arst_quiet_count: got %0d want 0", count); else passed++;
    endtask

    initial begin
        test_reset();
        test_push();
        test_commit();
        test_mispredict();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
